// File: rtl/spi_mem_master.sv
// spi_mem_master
//   SPI mode-0 master linking the CPU core to an external SPI SRAM/ROM.
//   Each accepted request runs one single-byte READ (0x03) or WRITE (0x02)
//   transaction: command byte, 16- or 24-bit address, then one data byte.
//   Chip-select steering between devices lives outside this block.
//
// Parameters
//   SCLK_DIV    clk cycles per sclk half-period (>=1); sclk = clk/(2*SCLK_DIV)
//
// Ports
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   start       in   level request, sampled only while idle
//   write       in   1 = WRITE, 0 = READ (latched at acceptance)
//   addr        in   24-bit byte address (latched at acceptance)
//   addr_24bit  in   1 = 24-bit address phase, 0 = addr[15:0] only (latched)
//   wr_data     in   byte to write (latched at acceptance)
//   rd_data     out  last byte read, held until the next read completes
//   done        out  one-cycle completion pulse
//   busy        out  high from the cycle after acceptance through the done cycle
//   sclk        out  SPI clock, idles low
//   cs_n        out  SPI chip select, active-low
//   mosi        out  SPI data out, MSB first
//   miso        in   SPI data in
module spi_mem_master #(
  parameter int SCLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        write,
  input  logic [23:0] addr,
  input  logic        addr_24bit,
  input  logic [7:0]  wr_data,
  output logic [7:0]  rd_data,
  output logic        done,
  output logic        busy,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi,
  input  logic        miso
);

  localparam int               DIV_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [7:0]       CMD_READ  = 8'h03;
  localparam logic [7:0]       CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_DONE,
    S_HOLD
  } state_t;

  // Whole outgoing frame, left-aligned so the bit on the wire is always
  // bit 39. A 16-bit frame is 32 bits long; its tail is padding that is
  // never shifted out. Read frames carry a zero data byte, which keeps
  // mosi low during the read data phase.
  function automatic logic [39:0] build_frame(input logic        is_write,
                                              input logic        wide,
                                              input logic [23:0] a,
                                              input logic [7:0]  wd);
    logic [7:0] cmd;
    logic [7:0] data_byte;
    cmd       = is_write ? CMD_WRITE : CMD_READ;
    data_byte = is_write ? wd : 8'h00;
    if (wide) return {cmd, a, data_byte};
    else      return {cmd, a[15:0], data_byte, 8'h00};
  endfunction

  state_t            state, state_nxt;
  logic              launch, launch_nxt;
  logic [5:0]        bit_cnt, bit_cnt_nxt;
  logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
  logic              sclk_q, sclk_nxt;
  logic              cs_n_q, cs_n_nxt;
  logic [39:0]       tx_sr, tx_sr_nxt;
  logic [7:0]        rx_sr, rx_sr_nxt;
  logic [7:0]        rd_data_q, rd_data_nxt;
  logic              wr_q, wr_nxt;
  logic              a24_q, a24_nxt;

  logic [5:0]        last_bit;
  logic [5:0]        addr_last;

  assign last_bit  = a24_q ? 6'd39 : 6'd31;
  assign addr_last = a24_q ? 6'd31 : 6'd23;

  always_comb begin
    state_nxt   = state;
    launch_nxt  = launch;
    bit_cnt_nxt = bit_cnt;
    div_cnt_nxt = div_cnt;
    sclk_nxt    = sclk_q;
    cs_n_nxt    = cs_n_q;
    tx_sr_nxt   = tx_sr;
    rx_sr_nxt   = rx_sr;
    rd_data_nxt = rd_data_q;
    wr_nxt      = wr_q;
    a24_nxt     = a24_q;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt   = S_CMD;
          launch_nxt  = 1'b1;
          bit_cnt_nxt = '0;
          div_cnt_nxt = '0;
          sclk_nxt    = 1'b0;
          wr_nxt      = write;
          a24_nxt     = addr_24bit;
          tx_sr_nxt   = build_frame(write, addr_24bit, addr, wr_data);
        end
      end

      S_CMD, S_ADDR, S_DATA: begin
        if (launch) begin
          // One setup cycle after acceptance: select the device and start
          // the first low half-period with cmd[7] already on mosi.
          launch_nxt = 1'b0;
          cs_n_nxt   = 1'b0;
        end else if (div_cnt != DIV_LAST) begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end else begin
          div_cnt_nxt = '0;
          if (!sclk_q) begin
            sclk_nxt  = 1'b1;
            rx_sr_nxt = {rx_sr[6:0], miso};
          end else begin
            sclk_nxt    = 1'b0;
            bit_cnt_nxt = bit_cnt + 6'd1;
            tx_sr_nxt   = {tx_sr[38:0], 1'b0};
            if (bit_cnt == last_bit) begin
              // Last falling edge doubles as the done edge; the read byte
              // is complete in rx_sr since its final rising edge.
              state_nxt   = S_DONE;
              cs_n_nxt    = 1'b1;
              bit_cnt_nxt = '0;
              tx_sr_nxt   = '0;
              if (!wr_q) rd_data_nxt = rx_sr;
            end else if (bit_cnt == 6'd7) begin
              state_nxt = S_ADDR;
            end else if (bit_cnt == addr_last) begin
              state_nxt = S_DATA;
            end
          end
        end
      end

      S_DONE: state_nxt = S_HOLD;

      // A level request held past completion must not start a second
      // transaction; wait for start to drop first.
      S_HOLD: if (!start) state_nxt = S_IDLE;

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      launch    <= 1'b0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      tx_sr     <= '0;
      rd_data_q <= 8'h00;
      wr_q      <= 1'b0;
      a24_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      launch    <= launch_nxt;
      bit_cnt   <= bit_cnt_nxt;
      div_cnt   <= div_cnt_nxt;
      sclk_q    <= sclk_nxt;
      cs_n_q    <= cs_n_nxt;
      tx_sr     <= tx_sr_nxt;
      rd_data_q <= rd_data_nxt;
      wr_q      <= wr_nxt;
      a24_q     <= a24_nxt;
    end
  end

  always_ff @(posedge clk) begin
    rx_sr <= rx_sr_nxt;
  end

  assign rd_data = rd_data_q;
  assign done    = (state == S_DONE);
  assign busy    = (state inside {S_CMD, S_ADDR, S_DATA, S_DONE});
  assign sclk    = sclk_q;
  assign cs_n    = cs_n_q;
  assign mosi    = tx_sr[39];

endmodule
